// File: rtl/tetris_render_agu.sv
// rtl/tetris_render_agu.sv - Tetris board/preview sprite address generator with line-clear flash FSM
//
// Purpose: maps the current screen pixel to a sprite/tile ROM address. Stage 1
// registers region hits and cell/sub-cell coordinates (and the board-memory
// read request); stage 2 combines the returned cell kind, preview kinds and
// flash state into sprite_addr. Pixel to sprite_addr latency is 2 clk.
//
// Ports:
//   clk, reset_n        pixel clock, asynchronous active-low reset
//   pixel_x, pixel_y    current screen coordinate
//   frame_start         one-cycle pulse at the start of each frame
//   cell_kind           board cell content for cell_col/cell_row (combinational)
//   preview_kinds       4-bit kind per preview slot, slot i at [4i+3:4i]
//   clear_start         flash request, clear_mask gives the rows to flash
//   cell_col, cell_row  registered board-memory read request
//   sprite_addr         registered ROM address
//   flash_busy          flash FSM not idle
//   clear_done          one-cycle pulse when a flash completes
module tetris_render_agu #(
   parameter int BOARD_COLS   = 10,
   parameter int BOARD_ROWS   = 20,
   parameter int CELL_PX      = 20,
   parameter int ORG_X        = 220,
   parameter int ORG_Y        = 40,
   parameter int TILE_W       = 40,
   parameter int NUM_PREVIEW  = 3,
   parameter int PREV_X       = 450,
   parameter int PREV_Y       = 70,
   parameter int PREV_PITCH   = 40,
   parameter int FLASH_FRAMES = 8,
   parameter int ADDR_W       = 17,
   parameter int BG_ADDR      = 25851,
   parameter int GRID_ADDR    = 25852
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [9:0]               pixel_x,
   input  logic [9:0]               pixel_y,
   input  logic                     frame_start,
   input  logic [3:0]               cell_kind,
   input  logic [4*NUM_PREVIEW-1:0] preview_kinds,
   input  logic                     clear_start,
   input  logic [BOARD_ROWS-1:0]    clear_mask,
   output logic [4:0]               cell_col,
   output logic [4:0]               cell_row,
   output logic [ADDR_W-1:0]        sprite_addr,
   output logic                     flash_busy,
   output logic                     clear_done
);

   localparam int TILE_SZ   = TILE_W * TILE_W;
   localparam int BOARD_W   = BOARD_COLS * CELL_PX;
   localparam int BOARD_H   = BOARD_ROWS * CELL_PX;
   localparam int HALF_PX   = CELL_PX / 2;
   localparam int SLOT_W    = 4 * HALF_PX;
   localparam int SLOT_H    = 2 * HALF_PX;
   localparam int SLOT_BITS = (NUM_PREVIEW > 1) ? $clog2(NUM_PREVIEW) : 1;
   localparam int CNT_W     = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

   localparam logic [ADDR_W-1:0] BG   = ADDR_W'(BG_ADDR);
   localparam logic [ADDR_W-1:0] GRID = ADDR_W'(GRID_ADDR);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLASH = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Shape masks: row 0 in bits [7:4], column 0 is the MSB of each nibble.
   function automatic logic [7:0] shape_mask(input logic [3:0] kind);
      case (kind)
         4'd1:    shape_mask = 8'hF0;
         4'd2:    shape_mask = 8'h8E;
         4'd3:    shape_mask = 8'h2E;
         4'd4:    shape_mask = 8'h66;
         4'd5:    shape_mask = 8'h6C;
         4'd6:    shape_mask = 8'h4E;
         4'd7:    shape_mask = 8'hC6;
         default: shape_mask = 8'h00;
      endcase
   endfunction

   // ---------------------------------------------------------------- stage 1
   logic                 in_board_d, in_board_q;
   logic [4:0]           cell_col_d, cell_col_q;
   logic [4:0]           cell_row_d, cell_row_q;
   logic [9:0]           rx_d, rx_q, ry_d, ry_q;
   logic                 prev_hit_d, prev_hit_q;
   logic [SLOT_BITS-1:0] slot_d, slot_q;
   logic [1:0]           pcol_d, pcol_q;
   logic                 prow_d, prow_q;
   logic [9:0]           sx_d, sx_q, sy_d, sy_q;

   // 32-bit working values so x/y = 1023 plus offsets never wrap; the region
   // tests are done before any subtraction result is used.
   logic [31:0] x_w, y_w, dx, dy, px, py, top;

   always_comb begin
      x_w = {22'd0, pixel_x};
      y_w = {22'd0, pixel_y};
      dx  = x_w - 32'(ORG_X);
      dy  = y_w - 32'(ORG_Y);

      in_board_d = (x_w >= 32'(ORG_X)) && (x_w < 32'(ORG_X + BOARD_W)) &&
                   (y_w >= 32'(ORG_Y)) && (y_w < 32'(ORG_Y + BOARD_H));
      cell_col_d = '0;
      cell_row_d = '0;
      rx_d       = '0;
      ry_d       = '0;
      if (in_board_d) begin
         cell_col_d = 5'(dx / 32'(CELL_PX));
         cell_row_d = 5'(dy / 32'(CELL_PX));
         rx_d       = 10'(dx % 32'(CELL_PX));
         ry_d       = 10'(dy % 32'(CELL_PX));
      end

      // Scan from the highest slot down so the lowest matching slot wins.
      prev_hit_d = 1'b0;
      slot_d     = '0;
      pcol_d     = '0;
      prow_d     = 1'b0;
      sx_d       = '0;
      sy_d       = '0;
      px         = x_w - 32'(PREV_X);
      py         = '0;
      top        = '0;
      for (int i = NUM_PREVIEW - 1; i >= 0; i--) begin
         top = 32'(PREV_Y + i * PREV_PITCH);
         if ((x_w >= 32'(PREV_X)) && (x_w < 32'(PREV_X + SLOT_W)) &&
             (y_w >= top) && (y_w < top + 32'(SLOT_H))) begin
            py         = y_w - top;
            prev_hit_d = 1'b1;
            slot_d     = SLOT_BITS'(i);
            pcol_d     = 2'(px / 32'(HALF_PX));
            prow_d     = 1'(py / 32'(HALF_PX));
            sx_d       = 10'(px);
            sy_d       = 10'(py);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_board_q <= 1'b0;
         cell_col_q <= '0;
         cell_row_q <= '0;
         rx_q       <= '0;
         ry_q       <= '0;
         prev_hit_q <= 1'b0;
         slot_q     <= '0;
         pcol_q     <= '0;
         prow_q     <= 1'b0;
         sx_q       <= '0;
         sy_q       <= '0;
      end else begin
         in_board_q <= in_board_d;
         cell_col_q <= cell_col_d;
         cell_row_q <= cell_row_d;
         rx_q       <= rx_d;
         ry_q       <= ry_d;
         prev_hit_q <= prev_hit_d;
         slot_q     <= slot_d;
         pcol_q     <= pcol_d;
         prow_q     <= prow_d;
         sx_q       <= sx_d;
         sy_q       <= sy_d;
      end
   end

   // ---------------------------------------------------------------- flash FSM
   state_t                state_q;
   logic [CNT_W-1:0]      frame_cnt_q;
   logic [BOARD_ROWS-1:0] mask_q;
   logic                  flash_busy_q;
   logic                  clear_done_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         frame_cnt_q  <= '0;
         mask_q       <= '0;
         flash_busy_q <= 1'b0;
         clear_done_q <= 1'b0;
      end else begin
         clear_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A coincident frame_start is not counted: the counter starts at 0.
               if (clear_start) begin
                  mask_q       <= clear_mask;
                  frame_cnt_q  <= '0;
                  flash_busy_q <= 1'b1;
                  if (clear_mask == '0) begin
                     state_q      <= DONE;
                     clear_done_q <= 1'b1;
                  end else begin
                     state_q <= FLASH;
                  end
               end
            end
            FLASH: begin
               if (frame_start) begin
                  if (frame_cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
                     state_q      <= DONE;
                     clear_done_q <= 1'b1;
                  end else begin
                     frame_cnt_q <= frame_cnt_q + 1'b1;
                  end
               end
            end
            DONE: begin
               state_q      <= IDLE;
               flash_busy_q <= 1'b0;
            end
            default: begin
               state_q      <= IDLE;
               flash_busy_q <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [3:0]        pk;
   logic [7:0]        pmask;
   logic [2:0]        bit_idx;
   logic              blank;
   logic [ADDR_W-1:0] sprite_addr_d, sprite_addr_q;

   always_comb begin
      pk      = preview_kinds[slot_q*4 +: 4];
      pmask   = shape_mask(pk);
      // Mask bit for (col,row) is 7 - (row*4 + col).
      bit_idx = 3'd7 - {prow_q, pcol_q};
      // Odd flash frames blank the latched rows.
      blank   = (state_q == FLASH) && frame_cnt_q[0] &&
                (cell_row_q < 5'(BOARD_ROWS)) && mask_q[cell_row_q];

      sprite_addr_d = BG;
      if (in_board_q) begin
         if (blank) begin
            sprite_addr_d = BG;
         end else if ((cell_kind >= 4'd1) && (cell_kind <= 4'd7)) begin
            sprite_addr_d = ADDR_W'((32'(cell_kind) - 32'd1) * 32'(TILE_SZ) +
                                    32'(ry_q) * 32'(TILE_W) + 32'(rx_q));
         end else if (cell_kind == 4'd0) begin
            sprite_addr_d = ((rx_q == '0) || (ry_q == '0)) ? GRID : BG;
         end
      end else if (prev_hit_q && (pk >= 4'd1) && (pk <= 4'd7) && pmask[bit_idx]) begin
         sprite_addr_d = ADDR_W'((32'(pk) - 32'd1) * 32'(TILE_SZ) +
                                 32'(sy_q) * 32'(TILE_W) + 32'(sx_q));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sprite_addr_q <= BG;
      end else begin
         sprite_addr_q <= sprite_addr_d;
      end
   end

   assign cell_col    = cell_col_q;
   assign cell_row    = cell_row_q;
   assign sprite_addr = sprite_addr_q;
   assign flash_busy  = flash_busy_q;
   assign clear_done  = clear_done_q;

endmodule

// File: tb/tb_tetris_render_agu.sv
// tb/tb_tetris_render_agu.sv - self-checking bench for tetris_render_agu
module tb_tetris_render_agu;

   localparam int BG   = 25851;
   localparam int GRID = 25852;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  pixel_x, pixel_y;
   logic        frame_start;
   logic [3:0]  cell_kind;
   logic [11:0] preview_kinds;
   logic        clear_start;
   logic [19:0] clear_mask;
   logic [4:0]  cell_col, cell_row;
   logic [16:0] sprite_addr;
   logic        flash_busy;
   logic        clear_done;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   logic [3:0]  board [20][10];
   logic [19:0] mask_model;

   // Shape of each kind: 4x2 grid, row 0 then row 1, '#' = lit.
   string shapes [8] = '{"........", "####....", "#...###.", "..#.###.",
                         ".##..##.", ".##.##..", ".#..###.", "##...##."};

   always #5 clk = ~clk;

   // Board memory answers the registered read request combinationally.
   assign cell_kind = (cell_row < 5'd20 && cell_col < 5'd10) ? board[cell_row][cell_col] : 4'd0;

   always @(negedge clk) if (clear_done === 1'b1) done_cnt++;

   tetris_render_agu dut (
      .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .frame_start(frame_start), .cell_kind(cell_kind), .preview_kinds(preview_kinds),
      .clear_start(clear_start), .clear_mask(clear_mask), .cell_col(cell_col),
      .cell_row(cell_row), .sprite_addr(sprite_addr), .flash_busy(flash_busy),
      .clear_done(clear_done)
   );

   function automatic int ref_addr(input int x, input int y, input bit odd, input logic [19:0] rows);
      if (x >= 220 && x < 420 && y >= 40 && y < 440) begin
         int col = (x - 220) / 20;
         int row = (y - 40) / 20;
         int rx  = (x - 220) % 20;
         int ry  = (y - 40) % 20;
         int k   = int'(board[row][col]);
         if (odd && rows[row]) return BG;
         if (k >= 1 && k <= 7) return (k - 1) * 1600 + ry * 40 + rx;
         if (k == 0) return (rx == 0 || ry == 0) ? GRID : BG;
         return BG;
      end
      for (int s = 0; s < 3; s++) begin
         int top = 70 + 40 * s;
         if (x >= 450 && x < 490 && y >= top && y < top + 20) begin
            int sx = x - 450;
            int sy = y - top;
            int k  = int'(preview_kinds[s*4 +: 4]);
            if (k >= 1 && k <= 7 && shapes[k][(sy / 10) * 4 + sx / 10] == "#")
               return (k - 1) * 1600 + sy * 40 + sx;
            return BG;
         end
      end
      return BG;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic probe(input int x, input int y, input int exp, input string tag);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      @(negedge clk);
      @(negedge clk);
      check(tag, 32'(sprite_addr), 32'(exp));
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic start_clear(input logic [19:0] m, input bit with_frame);
      clear_mask  = m;
      clear_start = 1'b1;
      frame_start = with_frame;
      @(negedge clk);
      clear_start = 1'b0;
      frame_start = 1'b0;
   endtask

   initial begin
      int d0;
      reset_n = 1'b0;
      pixel_x = '0; pixel_y = '0; frame_start = 1'b0;
      preview_kinds = '0; clear_start = 1'b0; clear_mask = '0;
      mask_model = '0;
      for (int r = 0; r < 20; r++) for (int c = 0; c < 10; c++) board[r][c] = 4'd0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_addr", 32'(sprite_addr), BG);
      check("rst_col", 32'(cell_col), 0);
      check("rst_row", 32'(cell_row), 0);
      check("rst_busy", 32'(flash_busy), 0);
      check("rst_done", 32'(clear_done), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Board origin pixel: 1 clk to the read request, 2 clk to the address
      board[0][0] = 4'd3;
      pixel_x = 10'd220; pixel_y = 10'd40;
      @(negedge clk);
      check("org_col", 32'(cell_col), 0);
      check("org_row", 32'(cell_row), 0);
      @(negedge clk);
      check("org_addr", 32'(sprite_addr), 3200);

      board[1][1] = 4'd2;
      probe(245, 67, 1885, "kind2");
      board[1][1] = 4'd0;
      probe(245, 67, BG, "empty_bg");
      board[1][0] = 4'd0;
      probe(240, 67, GRID, "empty_grid");
      board[1][1] = 4'd9;
      probe(245, 67, BG, "kind_gt7");

      probe(219, 40, BG, "left_edge");
      probe(420, 40, BG, "right_edge");
      probe(1023, 1023, BG, "far_corner");
      pixel_x = 10'd419; pixel_y = 10'd439;
      @(negedge clk);
      check("last_col", 32'(cell_col), 9);
      check("last_row", 32'(cell_row), 19);

      preview_kinds = 12'h010;
      probe(455, 115, 205, "prev_lit");
      probe(455, 125, BG, "prev_unlit");

      // Randomised pipelined stream against the reference model
      for (int r = 0; r < 20; r++) for (int c = 0; c < 10; c++) board[r][c] = 4'($urandom_range(0, 15));
      for (int s = 0; s < 3; s++) preview_kinds[s*4 +: 4] = 4'($urandom_range(0, 7));
      begin
         int ex[$];
         for (int i = 0; i < 400; i++) begin
            int x, y;
            case ($urandom_range(0, 3))
               0: begin x = $urandom_range(200, 440); y = $urandom_range(20, 460); end
               1: begin x = $urandom_range(440, 500); y = $urandom_range(60, 200); end
               2: begin x = $urandom_range(0, 1023);  y = $urandom_range(0, 1023); end
               default: begin x = ($urandom_range(0, 1) != 0) ? 1023 : 0; y = ($urandom_range(0, 1) != 0) ? 1023 : 0; end
            endcase
            if (i >= 2) check("rand_pipe", 32'(sprite_addr), 32'(ex[i-2]));
            pixel_x = 10'(x);
            pixel_y = 10'(y);
            ex.push_back(ref_addr(x, y, 1'b0, '0));
            @(negedge clk);
         end
      end

      // Flash of row 19; a second request mid-flash must be ignored
      board[19][0] = 4'd1;
      board[18][0] = 4'd2;
      mask_model = 20'h80000;
      d0 = done_cnt;
      start_clear(mask_model, 1'b0);
      check("flash_busy_on", 32'(flash_busy), 1);
      start_clear(20'h40000, 1'b0);
      probe(225, 425, ref_addr(225, 425, 1'b0, mask_model), "flash_f0_r19");
      for (int f = 1; f <= 8; f++) begin
         pulse_frame();
         if (f < 8) begin
            probe(225, 425, ref_addr(225, 425, (f % 2) == 1, mask_model), "flash_r19");
            probe(225, 405, ref_addr(225, 405, (f % 2) == 1, mask_model), "flash_r18");
            check("flash_busy_mid", 32'(flash_busy), 1);
         end
      end
      repeat (3) @(negedge clk);
      check("flash_done_once", 32'(done_cnt - d0), 1);
      check("flash_busy_off", 32'(flash_busy), 0);

      // Reset during frame 4 abandons the flash
      d0 = done_cnt;
      start_clear(mask_model, 1'b0);
      repeat (4) pulse_frame();
      reset_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(flash_busy), 0);
      check("rst_mid_addr", 32'(sprite_addr), BG);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mid_nodone", 32'(done_cnt - d0), 0);

      // Restart with a coincident frame_start, which must not be counted
      start_clear(mask_model, 1'b1);
      check("restart_busy", 32'(flash_busy), 1);
      probe(225, 425, ref_addr(225, 425, 1'b0, mask_model), "coinc_f0");
      pulse_frame();
      probe(225, 425, ref_addr(225, 425, 1'b1, mask_model), "coinc_f1");
      repeat (7) pulse_frame();
      repeat (3) @(negedge clk);
      check("restart_done", 32'(done_cnt - d0), 1);
      check("restart_idle", 32'(flash_busy), 0);

      // All-zero mask completes at once
      d0 = done_cnt;
      start_clear(20'h0, 1'b0);
      repeat (3) @(negedge clk);
      check("zero_mask_done", 32'(done_cnt - d0), 1);
      check("zero_mask_idle", 32'(flash_busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
